// File: rtl/ast_fifo_sched_if.sv
// Control/status bundle between the FIFO-bank sequencer and its tile controller.
// The FIFO-facing vectors travel with it so one handle carries the whole edge.
interface ast_fifo_sched_if #(
    parameter int NUM_FIFOS = 8
);
    logic                 start;
    logic                 abort;
    logic                 stall;
    logic                 tile_ready;
    logic                 busy;
    logic                 done;
    logic [NUM_FIFOS-1:0] rst_ptr_o;
    logic [NUM_FIFOS-1:0] load_o;
    logic [NUM_FIFOS-1:0] pop_o;
    logic [NUM_FIFOS-1:0] out_valid;

    modport master (
        output start, abort, stall,
        input  tile_ready, busy, done, rst_ptr_o, load_o, pop_o, out_valid
    );

    modport slave (
        input  start, abort, stall,
        output tile_ready, busy, done, rst_ptr_o, load_o, pop_o, out_valid
    );
endinterface

// File: rtl/ast_fifo_sched.sv
// Tile sequencer for a bank of ast_ldfifo instances: clear, load, skewed pop
// wavefront into the systolic array, drain, done.

// One row of the wavefront: pops while the shared stream index lies in this
// row's window, and flags the registered FIFO output one cycle later.
module ast_fifo_sched_row #(
    parameter int ROW   = 0,
    parameter int DEPTH = 8,
    parameter int TW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [TW-1:0] t,
    output logic          pop,
    output logic          vld
);
    localparam logic [TW-1:0] LO  = TW'(ROW);
    localparam logic [TW-1:0] LEN = TW'(DEPTH);

    // Modular distance: t below LO wraps far above LEN, so one compare covers both bounds.
    logic [TW-1:0] rel;
    assign rel = t - LO;
    assign pop = en && (rel < LEN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     vld <= 1'b0;
        else if (clr) vld <= 1'b0;
        else          vld <= pop;
    end
endmodule

module ast_fifo_sched #(
    parameter int NUM_FIFOS    = 8,
    parameter int DEPTH        = 8,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst,
    ast_fifo_sched_if.slave bus
);
    localparam int TW = $clog2(DEPTH + NUM_FIFOS);
    localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(DEPTH + NUM_FIFOS - 2);
    localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_STREAM, S_DRAIN, S_DONE, S_ABORT
    } state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  t, t_nxt;
    logic [DW-1:0]  d, d_nxt;
    logic           tile_ready, busy, done, clr_ptr, load, pop_en, vld_clr;
    logic [NUM_FIFOS-1:0] pop, vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            t     <= '0;
            d     <= '0;
        end else begin
            state <= state_nxt;
            t     <= t_nxt;
            d     <= d_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        t_nxt      = '0;
        d_nxt      = '0;
        tile_ready = (state == S_IDLE);
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        clr_ptr    = (state == S_CLEAR) || (state == S_ABORT);
        load       = (state == S_LOAD);
        pop_en     = (state == S_STREAM) && !bus.stall && !bus.abort;
        vld_clr    = (state == S_IDLE) || (state == S_ABORT);

        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_STREAM;
            S_STREAM: begin
                t_nxt = t;
                if (!bus.stall) begin
                    if (t == T_LAST) begin
                        state_nxt = (DRAIN_CYCLES > 0) ? S_DRAIN : S_DONE;
                        t_nxt     = '0;
                    end else begin
                        t_nxt = t + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                d_nxt = d;
                if (!bus.stall) begin
                    if (d == D_LAST) begin
                        state_nxt = S_DONE;
                        d_nxt     = '0;
                    end else begin
                        d_nxt = d + 1'b1;
                    end
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            S_ABORT:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase

        // Abort overrides every in-flight transition, including stall holds.
        if (bus.abort && (state != S_IDLE) && (state != S_ABORT)) begin
            state_nxt = S_ABORT;
            t_nxt     = '0;
            d_nxt     = '0;
        end
    end

    for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_row
        ast_fifo_sched_row #(.ROW(i), .DEPTH(DEPTH), .TW(TW)) u_row (
            .clk (clk),
            .rst (rst),
            .en  (pop_en),
            .clr (vld_clr),
            .t   (t),
            .pop (pop[i]),
            .vld (vld[i])
        );
    end

    assign bus.tile_ready = tile_ready;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.rst_ptr_o  = {NUM_FIFOS{clr_ptr}};
    assign bus.load_o     = {NUM_FIFOS{load}};
    assign bus.pop_o      = pop;
    assign bus.out_valid  = vld;
endmodule

// File: tb/tb_ast_fifo_sched.sv
// Bench for ast_fifo_sched: two instances (drain 3 and drain 0) share stimulus
// and are compared every cycle to a position-counter reference model.
module tb_ast_fifo_sched;
    localparam int N = 4;
    localparam int D = 4;
    localparam int S = D + N - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ast_fifo_sched_if #(.NUM_FIFOS(N)) ia ();
    ast_fifo_sched_if #(.NUM_FIFOS(N)) i0 ();

    ast_fifo_sched #(.NUM_FIFOS(N), .DEPTH(D), .DRAIN_CYCLES(3)) dut (
        .clk(clk), .rst(rst), .bus(ia));
    ast_fifo_sched #(.NUM_FIFOS(N), .DEPTH(D), .DRAIN_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(i0));

    // {ready, busy, done, rst_ptr[15:12], load[11:8], pop[7:4], out_valid[3:0]}
    wire [18:0] oa = {ia.tile_ready, ia.busy, ia.done, ia.rst_ptr_o, ia.load_o, ia.pop_o, ia.out_valid};
    wire [18:0] o0 = {i0.tile_ready, i0.busy, i0.done, i0.rst_ptr_o, i0.load_o, i0.pop_o, i0.out_valid};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a tile is a position along clear(0), load(1), stream beats, drain
    // beats, done. Stall freezes the position only inside stream/drain.
    bit       m_act [2];
    bit       m_abt [2];
    int       m_pos [2];
    logic [3:0] m_prev [2];

    function automatic int drain_of(input int u);
        return (u == 0) ? 3 : 0;
    endfunction

    function automatic logic [18:0] model_out(input int u, input logic a, input logic sl);
        logic [18:0] e;
        bit idle;
        int b;
        e    = '0;
        idle = !m_act[u] && !m_abt[u];
        e[18] = idle;
        e[17] = !idle;
        e[16] = m_act[u] && (m_pos[u] == 2 + S + drain_of(u));
        if (m_abt[u] || (m_act[u] && m_pos[u] == 0)) e[15:12] = 4'hF;
        if (m_act[u] && m_pos[u] == 1) e[11:8] = 4'hF;
        for (int i = 0; i < N; i++) begin
            b = m_pos[u] - 2 - i;
            if (m_act[u] && m_pos[u] >= 2 && m_pos[u] < 2 + S && !sl && !a && b >= 0 && b < D)
                e[4+i] = 1'b1;
        end
        e[3:0] = m_prev[u];
        return e;
    endfunction

    task automatic model_adv(input int u, input logic s, input logic a, input logic sl, input logic [3:0] pop);
        int last;
        last = 2 + S + drain_of(u);
        m_prev[u] = pop;
        if (m_abt[u]) m_abt[u] = 1'b0;
        else if (!m_act[u]) begin
            if (s) begin m_act[u] = 1'b1; m_pos[u] = 0; end
        end else if (a) begin
            m_act[u] = 1'b0; m_abt[u] = 1'b1;
        end else if (m_pos[u] == last) m_act[u] = 1'b0;
        else if (!(sl && m_pos[u] >= 2)) m_pos[u]++;
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_act[u] = 0; m_abt[u] = 0; m_pos[u] = 0; m_prev[u] = '0;
        end
    endtask

    logic [18:0] hist_a [64];
    logic [18:0] hist_0 [64];
    int k;

    // Entered at posedge+1; drives one cycle, checks both instances, advances.
    task automatic step(input logic s, input logic a, input logic sl);
        logic [18:0] ea, e0;
        ia.start = s; ia.abort = a; ia.stall = sl;
        i0.start = s; i0.abort = a; i0.stall = sl;
        #2;
        ea = model_out(0, a, sl);
        e0 = model_out(1, a, sl);
        chk("dut outputs", 32'(oa), 32'(ea));
        chk("dut_dr0 outputs", 32'(o0), 32'(e0));
        if (k < 64) begin hist_a[k] = oa; hist_0[k] = o0; end
        k++;
        model_adv(0, s, a, sl, ea[7:4]);
        model_adv(1, s, a, sl, e0[7:4]);
        @(posedge clk); #1;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while ((m_act[0] || m_abt[0] || m_act[1] || m_abt[1]) && n < 40) begin
            step(0, 0, 0);
            n++;
        end
        chk("settle to idle", 32'(n < 40), 32'd1);
        k = 0;
    endtask

    typedef struct {
        logic       start;
        logic       ready, busy, done;
        logic [3:0] rptr, load, pop;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int pc [N];
        logic [31:0] mask;
        logic dn;

        tbl[0]  = '{1, 1, 0, 0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{0, 0, 1, 0, 4'hF, 4'h0, 4'h0};
        tbl[2]  = '{0, 0, 1, 0, 4'h0, 4'hF, 4'h0};
        tbl[3]  = '{0, 0, 1, 0, 4'h0, 4'h0, 4'b0001};
        tbl[4]  = '{0, 0, 1, 0, 4'h0, 4'h0, 4'b0011};
        tbl[5]  = '{0, 0, 1, 0, 4'h0, 4'h0, 4'b0111};
        tbl[6]  = '{0, 0, 1, 0, 4'h0, 4'h0, 4'b1111};
        tbl[7]  = '{0, 0, 1, 0, 4'h0, 4'h0, 4'b1110};
        tbl[8]  = '{0, 0, 1, 0, 4'h0, 4'h0, 4'b1100};
        tbl[9]  = '{0, 0, 1, 0, 4'h0, 4'h0, 4'b1000};
        tbl[10] = '{0, 0, 1, 0, 4'h0, 4'h0, 4'h0};
        tbl[11] = '{0, 0, 1, 0, 4'h0, 4'h0, 4'h0};
        tbl[12] = '{0, 0, 1, 0, 4'h0, 4'h0, 4'h0};
        tbl[13] = '{0, 0, 1, 1, 4'h0, 4'h0, 4'h0};
        tbl[14] = '{0, 1, 0, 0, 4'h0, 4'h0, 4'h0};

        ia.start = 0; ia.abort = 0; ia.stall = 0;
        i0.start = 0; i0.abort = 0; i0.stall = 0;
        model_reset();
        k = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset state dut", 32'(oa), 32'h40000);
        chk("reset state dut_dr0", 32'(o0), 32'h40000);
        rst = 1'b1;
        @(posedge clk); #1;

        // Nominal tile against the literal table
        for (int c = 0; c < 15; c++) begin
            step(tbl[c].start, 0, 0);
            chk($sformatf("nominal c%0d", c), 32'(hist_a[c][18:4]),
                32'({tbl[c].ready, tbl[c].busy, tbl[c].done, tbl[c].rptr, tbl[c].load, tbl[c].pop}));
        end
        chk("dr0 done after last stream", 32'({hist_0[9][7:4], hist_0[10][16]}), 32'b1000_1);
        settle();

        // Stall in stream: pop_o[0] gaps and done slips by two
        for (int c = 0; c < 17; c++) step(c == 0, 0, c == 5 || c == 6);
        mask = '0;
        for (int c = 0; c < 17; c++) mask[c] = hist_a[c][4];
        chk("stall pop0 cycles", mask, 32'h198);
        chk("stall done cycle", 32'({hist_a[13][16], hist_a[14][16], hist_a[15][16]}), 32'b001);
        settle();

        // Stall in drain holds the drain count
        for (int c = 0; c < 16; c++) step(c == 0, 0, c == 11);
        chk("drain stall done", 32'({hist_a[13][16], hist_a[14][16]}), 32'b01);
        settle();

        // Abort mid-stream
        for (int c = 0; c < 13; c++) step(c == 0, c == 7, 0);
        dn = 1'b0;
        for (int c = 0; c < 13; c++) dn |= hist_a[c][16];
        chk("abort pops suppressed", 32'(hist_a[7][7:4]), 32'h0);
        chk("abort rst_ptr", 32'(hist_a[8][15:12]), 32'hF);
        chk("abort ready", 32'(hist_a[9][18]), 32'd1);
        chk("abort no done", 32'(dn), 32'd0);
        settle();

        // start held high: back-to-back tiles
        for (int c = 0; c < 29; c++) step(c < 28, 0, 0);
        for (int i = 0; i < N; i++) begin
            pc[i] = 0;
            for (int c = 0; c < 29; c++) pc[i] += int'(hist_a[c][4+i]);
            chk($sformatf("b2b pops fifo%0d", i), 32'(pc[i]), 32'd8);
            pc[i] = 0;
            for (int c = 0; c < 22; c++) pc[i] += int'(hist_0[c][4+i]);
            chk($sformatf("b2b dr0 pops fifo%0d", i), 32'(pc[i]), 32'd8);
        end
        chk("b2b idle then clear", 32'({hist_a[14][18], hist_a[15][15:12]}), 32'h1F);
        chk("b2b second done", 32'(hist_a[27][16]), 32'd1);
        settle();

        // Async reset mid-stream
        for (int c = 0; c < 6; c++) step(c == 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async rst pop", 32'(ia.pop_o), 32'h0);
        chk("async rst busy/ready", 32'({ia.busy, ia.tile_ready}), 32'b01);
        model_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        k = 0;
        step(1, 0, 0);
        step(0, 0, 0);
        chk("start after reset", 32'(hist_a[1][15:12]), 32'hF);
        settle();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++)
            step($urandom_range(2) == 0, $urandom_range(19) == 0, $urandom_range(3) == 0);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
